// File: rtl/serial_pkt_src.sv
// serial_pkt_src
//   Buffers four payload bytes, then on request sends a 40-bit serial packet:
//   one header byte (A5 or C3) followed by the four payload bytes in load
//   order, every byte MSB first, every bit held BIT_DIV clocks. After the
//   packet a GAP_CYC-cycle idle gap is enforced before the next load/start.
//
// Parameters
//   BIT_DIV  clk_50 cycles per serial bit (1..16)
//   GAP_CYC  idle cycles after a packet before returning to IDLE (1..255)
//
// Ports
//   clk_50       in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   byte_in      in   payload byte offered for loading
//   byte_valid   in   byte_in valid this cycle
//   byte_ready   out  byte accepted this cycle (IDLE and buffer not full)
//   hdr_sel      in   header choice sampled with tx_start: 0 = A5, 1 = C3
//   tx_start     in   transmit request, honoured only in IDLE with 4 bytes
//   serial_data  out  registered serial bit, 0 whenever data_ena is 0
//   data_ena     out  registered, high for every packet bit cycle
//   busy         out  high in HDR, DATA, GAP
//   pkt_done     out  one-cycle pulse in the first GAP cycle
module serial_pkt_src #(
  parameter int BIT_DIV = 1,
  parameter int GAP_CYC = 4
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       hdr_sel,
  input  logic       tx_start,
  output logic       serial_data,
  output logic       data_ena,
  output logic       busy,
  output logic       pkt_done
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  localparam logic [3:0] DIV_LAST = 4'(BIT_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state, state_nxt;
  logic [2:0]  count;
  logic [7:0]  buf_q [4];
  logic        hdr_q;
  logic [3:0]  div_cnt, div_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [7:0]  gap_cnt;
  logic [7:0]  byte_nxt;
  logic        accept, start, bit_end, byte_end;
  logic        ser_d, ena_d, done_d;

  assign byte_ready = (state == IDLE) && (count < 3'd4);
  assign accept     = byte_valid && byte_ready;
  // count == 4 implies byte_ready is low, so a same-edge load always wins
  assign start      = (state == IDLE) && tx_start && (count == 3'd4);
  assign bit_end    = (div_cnt == DIV_LAST);
  assign byte_end   = bit_end && (bit_cnt == 3'd7);
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)                     state_nxt = HDR;
      HDR:  if (byte_end)                  state_nxt = DATA;
      DATA: if (byte_end && idx == 2'd3)   state_nxt = GAP;
      GAP:  if (gap_cnt == GAP_LAST)       state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Output logic: the outputs are registered, so this computes the bit that
  // will be on the line in the cycle after the coming edge.
  always_comb begin
    div_nxt  = 4'd0;
    bit_nxt  = 3'd0;
    idx_nxt  = 2'd0;
    byte_nxt = 8'h00;
    if (state == HDR || state == DATA) begin
      div_nxt = bit_end ? 4'd0 : div_cnt + 4'd1;
      bit_nxt = bit_end ? bit_cnt + 3'd1 : bit_cnt;
      idx_nxt = (state == DATA && byte_end) ? idx + 2'd1 : idx;
    end
    unique case (state_nxt)
      HDR:     byte_nxt = ((state == IDLE) ? hdr_sel : hdr_q) ? 8'hC3 : 8'hA5;
      DATA:    byte_nxt = buf_q[idx_nxt];
      default: byte_nxt = 8'h00;
    endcase
    ena_d  = (state_nxt == HDR) || (state_nxt == DATA);
    ser_d  = ena_d && byte_nxt[3'd7 - bit_nxt];
    done_d = (state == DATA) && (state_nxt == GAP);
  end

  // Control and output registers
  always_ff @(posedge clk_50) begin
    if (reset) begin
      count       <= 3'd0;
      hdr_q       <= 1'b0;
      div_cnt     <= 4'd0;
      bit_cnt     <= 3'd0;
      idx         <= 2'd0;
      gap_cnt     <= 8'd0;
      serial_data <= 1'b0;
      data_ena    <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      if (done_d)      count <= 3'd0;
      else if (accept) count <= count + 3'd1;
      if (start) hdr_q <= hdr_sel;
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      idx         <= idx_nxt;
      if (state == GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? 8'd0 : gap_cnt + 8'd1;
      else              gap_cnt <= 8'd0;
      serial_data <= ser_d;
      data_ena    <= ena_d;
      pkt_done    <= done_d;
    end
  end

  // Payload buffer (data only, not reset; count gates its use)
  always_ff @(posedge clk_50) begin
    if (accept) buf_q[count[1:0]] <= byte_in;
  end

endmodule

// File: tb/tb_serial_pkt_src.sv
module tb_serial_pkt_src;

  logic       clk_50 = 1'b0;
  logic       rst_v [2];
  logic       bv_v  [2];
  logic       ts_v  [2];
  logic       hs_v  [2];
  logic [7:0] bin_v [2];
  logic       ser_v [2];
  logic       ena_v [2];
  logic       busy_v[2];
  logic       done_v[2];
  logic       rdy_v [2];

  int n_vec = 0;
  int n_err = 0;
  int lat;

  always #5 clk_50 = ~clk_50;

  serial_pkt_src #(.BIT_DIV(1), .GAP_CYC(4)) u_d1 (
    .clk_50(clk_50), .reset(rst_v[0]), .byte_in(bin_v[0]), .byte_valid(bv_v[0]),
    .byte_ready(rdy_v[0]), .hdr_sel(hs_v[0]), .tx_start(ts_v[0]),
    .serial_data(ser_v[0]), .data_ena(ena_v[0]), .busy(busy_v[0]), .pkt_done(done_v[0]));

  serial_pkt_src #(.BIT_DIV(3), .GAP_CYC(2)) u_d3 (
    .clk_50(clk_50), .reset(rst_v[1]), .byte_in(bin_v[1]), .byte_valid(bv_v[1]),
    .byte_ready(rdy_v[1]), .hdr_sel(hs_v[1]), .tx_start(ts_v[1]),
    .serial_data(ser_v[1]), .data_ena(ena_v[1]), .busy(busy_v[1]), .pkt_done(done_v[1]));

  task automatic tick();
    @(negedge clk_50);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int w, input logic [7:0] b);
    bv_v[w] = 1'b1; bin_v[w] = b;
    tick();
    bv_v[w] = 1'b0;
  endtask

  task automatic start(input int w, input logic hs);
    ts_v[w] = 1'b1; hs_v[w] = hs;
    tick();
    ts_v[w] = 1'b0;
  endtask

  // Waits (bounded) for data_ena, checks the whole packet, the pkt_done
  // pulse and the gap length; returns at the first IDLE cycle.
  task automatic capture(input int w, input int d, input int gap,
                         input logic [39:0] exp, output int l);
    int gaps, errs;
    l = 0;
    while (ena_v[w] !== 1'b1 && l < 20) begin tick(); l++; end
    check("pkt_start", ena_v[w], 1);
    gaps = 0; errs = 0;
    for (int k = 0; k < 40 * d; k++) begin
      if (ena_v[w] !== 1'b1) gaps++;
      if (ser_v[w] !== exp[39 - k / d]) errs++;
      tick();
    end
    check("ena_gaps", gaps, 0);
    check("bit_errs", errs, 0);
    check("ena_end", ena_v[w], 0);
    check("ser_end", ser_v[w], 0);
    check("done_pulse", done_v[w], 1);
    check("rdy_in_gap", rdy_v[w], 0);
    tick();
    check("done_once", done_v[w], 0);
    repeat (gap - 2) tick();
    check("busy_gap_last", busy_v[w], 1);
    tick();
    check("busy_idle", busy_v[w], 0);
    check("rdy_idle", rdy_v[w], 1);
  endtask

  initial begin
    int dcnt;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; bv_v[i] = 1'b0; ts_v[i] = 1'b0; hs_v[i] = 1'b0; bin_v[i] = 8'h00;
    end
    repeat (3) tick();
    check("rst_ena", ena_v[0], 0);
    check("rst_ser", ser_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_ena3", ena_v[1], 0);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    tick();
    check("rst_rdy", rdy_v[0], 1);

    // start with only two bytes is ignored
    load(0, 8'h11); load(0, 8'h22);
    start(0, 1'b0);
    check("short_ena", ena_v[0], 0);
    check("short_rdy", rdy_v[0], 1);
    check("short_busy", busy_v[0], 0);
    tick();
    check("short_ena2", ena_v[0], 0);
    load(0, 8'h33); load(0, 8'h44);
    check("full_rdy", rdy_v[0], 0);
    start(0, 1'b0);
    capture(0, 1, 4, 40'hA5_11223344, lat);
    check("lat_a5", lat, 0);

    // load and start on the same edge at count 3: load wins
    load(0, 8'h5A); load(0, 8'h0F); load(0, 8'hF0);
    bv_v[0] = 1'b1; bin_v[0] = 8'h81; ts_v[0] = 1'b1; hs_v[0] = 1'b1;
    tick();
    bv_v[0] = 1'b0; ts_v[0] = 1'b0;
    check("same_ena", ena_v[0], 0);
    check("same_busy", busy_v[0], 0);
    check("same_rdy", rdy_v[0], 0);
    tick();
    check("same_ena2", ena_v[0], 0);
    start(0, 1'b1);
    capture(0, 1, 4, 40'hC3_5A0FF081, lat);
    check("lat_c3", lat, 0);

    // reset in the middle of a packet
    load(0, 8'hAA); load(0, 8'h55); load(0, 8'h01); load(0, 8'h80);
    start(0, 1'b0);
    repeat (17) tick();
    check("mid_ena", ena_v[0], 1);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("mrst_ena", ena_v[0], 0);
    check("mrst_ser", ser_v[0], 0);
    check("mrst_done", done_v[0], 0);
    check("mrst_busy", busy_v[0], 0);
    check("mrst_rdy", rdy_v[0], 1);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_v[0] === 1'b1) dcnt++;
      tick();
    end
    check("mrst_no_done", dcnt, 0);
    load(0, 8'h3C); load(0, 8'hC3); load(0, 8'h96);
    check("mrst_rdy3", rdy_v[0], 1);
    load(0, 8'h69);
    check("mrst_rdy4", rdy_v[0], 0);
    start(0, 1'b0);
    capture(0, 1, 4, 40'hA5_3CC39669, lat);
    check("lat_post_rst", lat, 0);

    // back-to-back with tx_start held; bytes offered while busy are dropped
    ts_v[0] = 1'b1; hs_v[0] = 1'b0;
    load(0, 8'h01); load(0, 8'h02); load(0, 8'h03); load(0, 8'h04);
    check("b2b_wait", ena_v[0], 0);
    bv_v[0] = 1'b1; bin_v[0] = 8'hEE;
    capture(0, 1, 4, 40'hA5_01020304, lat);
    check("lat_b2b1", lat, 1);
    load(0, 8'h12); load(0, 8'h34); load(0, 8'h56); load(0, 8'h78);
    capture(0, 1, 4, 40'hA5_12345678, lat);
    check("lat_b2b2", lat, 1);
    ts_v[0] = 1'b0;

    // BIT_DIV = 3, header C3
    load(1, 8'h11); load(1, 8'h22); load(1, 8'h33); load(1, 8'h44);
    start(1, 1'b1);
    capture(1, 3, 2, 40'hC3_11223344, lat);
    check("lat_div3", lat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_pkt_src.md
SERIAL_PKT_SRC -- requirements
Module: serial_pkt_src

Interface
REQ-001 The block SHALL have parameter BIT_DIV, default 1, meaning clk_50 cycles per serial bit (legal 1..16).
REQ-002 The block SHALL have parameter GAP_CYC, default 4, meaning minimum idle clk_50 cycles with data_ena low between packets (legal 1..255).
REQ-003 The block SHALL have port clk_50  input  1  sole clock; all flops on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port byte_in  input  8  payload byte offered for loading.
REQ-006 The block SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-007 The block SHALL have port byte_ready  output  1  block accepts byte_in this cycle.
REQ-008 The block SHALL have port hdr_sel  input  1  header choice sampled with tx_start: 0 = 8'hA5, 1 = 8'hC3.
REQ-009 The block SHALL have port tx_start  input  1  request to transmit the loaded packet.
REQ-010 The block SHALL have port serial_data  output  1  serial bit stream, registered.
REQ-011 The block SHALL have port data_ena  output  1  high for every cycle serial_data carries a packet bit, registered.
REQ-012 The block SHALL have port busy  output  1  high in states HDR, DATA, GAP.
REQ-013 The block SHALL have port pkt_done  output  1  one-cycle pulse at packet end.

Function
REQ-014 The block SHALL implement FSM states IDLE, HDR, DATA, GAP.
REQ-015 byte_ready SHALL be high only when state is IDLE and the 4-entry payload buffer count is below 4.
REQ-016 A byte SHALL be accepted on a rising edge where byte_valid and byte_ready are both high; it is stored at index count, count increments by 1.
REQ-017 In IDLE, tx_start with count == 4 (value before the edge) SHALL latch hdr_sel and move to HDR; tx_start with count < 4 SHALL be ignored with no state change.
REQ-018 If byte_valid, byte_ready and tx_start are high together with count == 3, the byte SHALL be accepted and tx_start ignored.
REQ-019 The first header bit SHALL appear on serial_data with data_ena high in the cycle after the accepting tx_start edge.
REQ-020 Packet SHALL be header byte then payload bytes 0..3 in load order, each byte MSB first: 40 bits total.
REQ-021 Each bit SHALL be held for exactly BIT_DIV cycles; data_ena SHALL stay high for 40*BIT_DIV contiguous cycles with no gaps.
REQ-022 HDR SHALL move to DATA after the 8th header bit; DATA SHALL move to GAP after the 32nd payload bit.
REQ-023 In the first GAP cycle data_ena and serial_data SHALL be 0, pkt_done SHALL be 1 for that cycle only, and count SHALL be cleared to 0.
REQ-024 GAP SHALL last exactly GAP_CYC cycles, then move to IDLE; tx_start and byte_valid SHALL be ignored outside IDLE.
REQ-025 serial_data SHALL be 0 whenever data_ena is 0.
REQ-026 Internal bit and divider counters SHALL wrap to 0 at each bit/byte boundary and never exceed their terminal values.

Reset
REQ-027 While reset is high at a rising edge, next-cycle values SHALL be: state IDLE, count 0, serial_data 0, data_ena 0, busy 0, pkt_done 0; byte_ready becomes 1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-packet SHALL drop data_ena to 0 on the next cycle, discard buffered bytes, and emit no pkt_done.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-030 BIT_DIV=1: load 11,22,33,44, tx_start hdr_sel=0 -> 40 cycles data_ena high, bits A5 11 22 33 44 MSB first, pkt_done pulse next cycle, busy low after GAP_CYC.
REQ-031 hdr_sel=1, BIT_DIV=3 -> header C3, each bit held 3 cycles, data_ena high exactly 120 cycles.
REQ-032 tx_start with only 2 bytes loaded -> no data_ena, byte_ready stays 1; after 2 more bytes and tx_start the packet sends normally.
REQ-033 byte_valid+tx_start same edge at count=3 -> byte accepted, no transmission; second tx_start starts packet.
REQ-034 Reset pulsed at bit 17 of packet -> data_ena 0 next cycle, no pkt_done, byte_ready 1 and count 0 afterwards.
REQ-035 Back-to-back: tx_start held high, bytes reloaded during GAP -> no loading while busy; next packet starts no earlier than GAP_CYC idle cycles plus reload.
